// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding and parameter limits.
package uart_ctrl_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned N_REQ_MIN   = 2;
    localparam int unsigned N_REQ_MAX   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SEND   = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first asserted request at or above ptr, wrapping.
module rr_picker
    import uart_ctrl_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             any
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((ptr + i) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among N_REQ byte producers,
// holding the grant until the owner's packet ends.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned N_REQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    input  logic [N_REQ-1:0]         i_req_last,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ out of range");
    end

    state_t             state, state_n;
    logic [N_REQ-1:0]   grant_n, ready_n, pick_grant;
    logic               pick_any;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n, grant_idx;
    logic [NB_DATA-1:0] data_n, sel_data;
    logic               last_q, last_n, sel_last;
    logic               start_n, busy_n, hs;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Route the current owner's byte and last flag; also recover its index.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (o_grant[k]) begin
                sel_data  = i_req_data[k*NB_DATA +: NB_DATA];
                sel_last  = i_req_last[k];
                grant_idx = PTR_W'(k);
            end
        end
    end

    assign hs = |(o_req_ready & i_req_valid);

    // Next state; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_n  = state;
        grant_n  = o_grant;
        rr_ptr_n = rr_ptr;
        data_n   = o_tx_data;
        last_n   = last_q;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_n = pick_grant;
                    state_n = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (hs) begin
                    data_n  = sel_data;
                    last_n  = sel_last;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: state_n = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        rr_ptr_n = PTR_W'((grant_idx + 1) % N_REQ);
                        grant_n  = '0;
                        state_n  = ST_IDLE;
                    end else begin
                        state_n = ST_ACCEPT;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        ready_n = (state_n == ST_ACCEPT) ? grant_n : '0;
        start_n = (state_n == ST_SEND);
        busy_n  = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            o_grant     <= '0;
            rr_ptr      <= '0;
            o_tx_data   <= '0;
            last_q      <= 1'b0;
            o_req_ready <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_n;
            o_grant     <= grant_n;
            rr_ptr      <= rr_ptr_n;
            o_tx_data   <= data_n;
            last_q      <= last_n;
            o_req_ready <= ready_n;
            o_tx_start  <= start_n;
            o_busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus TX-model sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [3:0]  grant;
    logic        busy;

    logic        tb_done;
    logic        model_en;
    logic        m_active, m_done;
    int          m_cnt;
    logic [7:0]  tx_log [64];
    int          tx_n;
    int          overlap_err;

    int          total, bad;

    logic [8:0]  rmem  [4][16];
    int          rhead [4];
    int          rcnt  [4];
    logic [3:0]  hs;

    always #5 clk = ~clk;

    assign tx_done = tb_done | (model_en & m_done);

    uart_tx_arbiter #(.NB_DATA(8), .N_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_done   (tx_done),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    // TX model: logs each started byte, pulses done 20 cycles after start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (model_en && tx_start) begin
                if (m_active) overlap_err <= overlap_err + 1;
                m_active      <= 1'b1;
                m_cnt         <= 0;
                tx_log[tx_n]  <= tx_data;
                tx_n          <= tx_n + 1;
            end else if (m_active) begin
                if (m_cnt == 18) begin
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        done;
        logic [3:0]  e_ready;
        logic        e_start;
        logic [7:0]  e_data;
        logic [3:0]  e_grant;
        logic        e_busy;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic dn, input logic [3:0] er, input logic es,
                                input logic [7:0] ed, input logic [3:0] eg, input logic eb);
        vec_t r;
        r.valid = v; r.data = d; r.last = l; r.done = dn;
        r.e_ready = er; r.e_start = es; r.e_data = ed; r.e_grant = eg; r.e_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 4; k++) begin
            rhead[k] = 0;
            rcnt[k]  = 0;
        end
        hs        = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l);
        rmem[k][rcnt[k]] = {l, b};
        rcnt[k]++;
    endtask

    function automatic bit reqs_empty();
        bit e = 1'b1;
        for (int k = 0; k < 4; k++) if (rhead[k] != rcnt[k]) e = 1'b0;
        return e;
    endfunction

    // One cycle of requester behaviour: retire handshaken bytes, present next heads.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 4; k++) if (hs[k]) rhead[k]++;
        for (int k = 0; k < 4; k++) begin
            if (rhead[k] < rcnt[k]) begin
                req_valid[k]        = 1'b1;
                req_data[k*8 +: 8]  = rmem[k][rhead[k]][7:0];
                req_last[k]         = rmem[k][rhead[k]][8];
            end else begin
                req_valid[k] = 1'b0;
            end
        end
        hs = req_valid & req_ready;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int  n = 0;
        bit  ok = 1'b0;
        while (n < budget && !ok) begin
            cycle();
            n++;
            ok = (busy == 1'b0) && reqs_empty();
        end
        check({name, "_idle_reached"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        total = 0; bad = 0;
        tx_n = 0; overlap_err = 0;
        tb_done = 1'b0; model_en = 1'b0;
        do_reset();
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data",  32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);

        vecs[0]  = mk(4'b0001, 32'h0000_0075, 4'b0001, 0, 4'b0001, 0, 8'h00, 4'b0001, 1);
        vecs[1]  = mk(4'b0001, 32'h0000_0075, 4'b0001, 0, 4'b0000, 1, 8'h75, 4'b0001, 1);
        vecs[2]  = mk(4'b0000, 32'h0000_0075, 4'b0000, 0, 4'b0000, 0, 8'h75, 4'b0001, 1);
        vecs[3]  = mk(4'b0000, 32'h0000_0075, 4'b0000, 1, 4'b0000, 0, 8'h75, 4'b0000, 0);
        vecs[4]  = mk(4'b0011, 32'h0000_1110, 4'b0011, 0, 4'b0010, 0, 8'h75, 4'b0010, 1);
        vecs[5]  = mk(4'b0011, 32'h0000_1110, 4'b0011, 0, 4'b0000, 1, 8'h11, 4'b0010, 1);
        vecs[6]  = mk(4'b0001, 32'h0000_1110, 4'b0011, 0, 4'b0000, 0, 8'h11, 4'b0010, 1);
        vecs[7]  = mk(4'b0001, 32'h0000_1110, 4'b0011, 1, 4'b0000, 0, 8'h11, 4'b0000, 0);
        vecs[8]  = mk(4'b0001, 32'h0000_1110, 4'b0011, 0, 4'b0001, 0, 8'h11, 4'b0001, 1);
        vecs[9]  = mk(4'b0000, 32'h0000_1110, 4'b0011, 1, 4'b0001, 0, 8'h11, 4'b0001, 1);
        vecs[10] = mk(4'b0001, 32'h0000_1110, 4'b0011, 0, 4'b0000, 1, 8'h10, 4'b0001, 1);
        vecs[11] = mk(4'b0000, 32'h0000_1110, 4'b0000, 0, 4'b0000, 0, 8'h10, 4'b0001, 1);
        vecs[12] = mk(4'b0000, 32'h0000_1110, 4'b0000, 1, 4'b0000, 0, 8'h10, 4'b0000, 0);
        vecs[13] = mk(4'b0000, 32'h0000_1110, 4'b0000, 1, 4'b0000, 0, 8'h10, 4'b0000, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            tb_done   = vecs[i].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d_start", i), 32'(tx_start),  32'(vecs[i].e_start));
            check($sformatf("vec%0d_data", i),  32'(tx_data),   32'(vecs[i].e_data));
            check($sformatf("vec%0d_grant", i), 32'(grant),     32'(vecs[i].e_grant));
            check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
        end
        @(negedge clk);
        tb_done = 1'b0;

        // Contention from reset: order 0,1,3 then again 0,1,3 after the pointer wraps.
        model_en = 1'b1;
        do_reset();
        base = tx_n;
        push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1); push(3, 8'hB3, 1'b1);
        run_until_idle("contend1", 200);
        push(0, 8'hC0, 1'b1); push(1, 8'hC1, 1'b1); push(3, 8'hC3, 1'b1);
        run_until_idle("contend2", 200);
        check("contend_count", 32'(tx_n - base), 32'd6);
        check("contend_b0", 32'(tx_log[base+0]), 32'hB0);
        check("contend_b1", 32'(tx_log[base+1]), 32'hB1);
        check("contend_b2", 32'(tx_log[base+2]), 32'hB3);
        check("contend_b3", 32'(tx_log[base+3]), 32'hC0);
        check("contend_b4", 32'(tx_log[base+4]), 32'hC1);
        check("contend_b5", 32'(tx_log[base+5]), 32'hC3);

        // Packet lock: req2 owns the TX for its whole packet although req0 waits.
        base = tx_n;
        push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
        n = 0;
        while (grant != 4'b0100 && n < 20) begin cycle(); n++; end
        check("lock_grant2", 32'(grant), 32'b0100);
        push(0, 8'hD0, 1'b1);
        run_until_idle("lock", 400);
        check("lock_b0", 32'(tx_log[base+0]), 32'hA1);
        check("lock_b1", 32'(tx_log[base+1]), 32'hA2);
        check("lock_b2", 32'(tx_log[base+2]), 32'hA3);
        check("lock_b3", 32'(tx_log[base+3]), 32'hD0);

        // Stalled packet: ACCEPT holds with ready1 and no start while req1 is silent.
        base = tx_n;
        push(1, 8'h3B, 1'b0);
        run_cycles(30);
        check("stall_first", 32'(tx_log[base]), 32'h3B);
        run_cycles(50);
        check("stall_ready", 32'(req_ready), 32'b0010);
        check("stall_grant", 32'(grant), 32'b0010);
        check("stall_busy",  32'(busy), 32'd1);
        check("stall_nostart", 32'(tx_n - base), 32'd1);
        push(1, 8'h3C, 1'b1);
        run_until_idle("stall", 100);
        check("stall_count", 32'(tx_n - base), 32'd2);
        check("stall_second", 32'(tx_log[base+1]), 32'h3C);
        check("stall_end_grant", 32'(grant), 32'd0);

        // Reset in WAIT of a packet's second byte.
        base = tx_n;
        push(0, 8'hF1, 1'b0); push(0, 8'hF2, 1'b1);
        n = 0;
        while (tx_n < base + 2 && n < 100) begin cycle(); n++; end
        check("rstw_second_started", 32'(tx_n - base), 32'd2);
        run_cycles(5);
        check("rstw_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstw_ready", 32'(req_ready), 32'd0);
        check("rstw_start", 32'(tx_start), 32'd0);
        check("rstw_data",  32'(tx_data), 32'd0);
        check("rstw_grant", 32'(grant), 32'd0);
        check("rstw_busy",  32'(busy), 32'd0);
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = tx_n;
        push(1, 8'h55, 1'b1); push(3, 8'h99, 1'b1);
        run_until_idle("rstw_after", 200);
        check("rstw_b0", 32'(tx_log[base+0]), 32'h55);
        check("rstw_b1", 32'(tx_log[base+1]), 32'h99);

        check("tx_overlap", 32'(overlap_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
